mul_div_unit: RTL and testbench
===============================

Name: mul_div_unit

Overview:
- Parametrised multi-cycle RV32M execute unit for the 5-stage pipeline; sits beside the integer ALU in the EX stage.
- Executes all eight M-extension ops (MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU) iteratively, retiring BITS_PER_CYCLE bits per cycle.
- Stalls the front end via BUSY, honours branch flushes and MEM-stage busywait holds, and returns a tagged result for the EX/MEM register.

Parameters:
- XLEN, 32, operand/result width
- BITS_PER_CYCLE, 1, bits of multiplier/quotient resolved per iteration; must divide XLEN (1, 2, 4 legal)
- REG_ADDR_W, 5, destination register tag width

Ports:
- CLK  in  1  clock; all state changes on rising edge
- RESET  in  1  synchronous, active-high reset
- START  in  1  request valid from ID/EX this cycle
- FUNC3  in  3  M-op select, RV32M funct3 encoding
- OP_A  in  XLEN  rs1 value (forwarded)
- OP_B  in  XLEN  rs2 value (forwarded)
- RD_ADDR  in  REG_ADDR_W  destination tag
- FLUSH  in  1  kill in-flight op (branch taken / hazard reset)
- HOLD  in  1  downstream stall (MEM busywait); freezes the result in DONE
- BUSY  out  1  pipeline must stall ID/EX
- RESULT_VALID  out  1  RESULT/RESULT_RD valid
- RESULT  out  XLEN  op result
- RESULT_RD  out  REG_ADDR_W  tag of RESULT

Behaviour:
- Clocking and reset: one clock, CLK. RESET is synchronous, active-high and dominates all inputs. On RESET: state IDLE; RESULT_VALID=0, RESULT=0, RESULT_RD=0; all internal accumulators cleared. RESET mid-operation aborts the op with no result.
- States: IDLE, CALC, FIX, DONE.
- IDLE:
  - START=1 and FLUSH=0: latch FUNC3, RD_ADDR, operand magnitudes, result-sign flag and iteration counter N=XLEN/BITS_PER_CYCLE.
  - Next state is CALC, except for the special cases below, which go directly to DONE.
  - START=1 and FLUSH=1: request ignored.
- CALC: resolve BITS_PER_CYCLE bits per cycle.
  - Multiply: shift-add into a 2*XLEN product.
  - Divide: restoring divide producing quotient and remainder.
  - Counter decrements each cycle; at 0, go to FIX.
- FIX: one cycle.
  - Negate the selected result if its sign flag is set.
  - Select the low (MUL) or high (MULH*) product half, or quotient/remainder.
  - Register into RESULT; go to DONE.
- DONE:
  - RESULT_VALID=1.
  - HOLD=1: stay in DONE; RESULT and RESULT_RD stay stable.
  - HOLD=0: go to IDLE next cycle with RESULT_VALID=0; RESULT keeps its last value.
- Latency:
  - Normal ops: RESULT_VALID asserts N+2 cycles after the accepting edge. XLEN=32: 34 cycles at BITS_PER_CYCLE=1; 10 cycles at BITS_PER_CYCLE=4.
  - Special cases: 1 cycle.
- BUSY = (START & state==IDLE & !FLUSH) | (state==CALC) | (state==FIX) | (state==DONE & HOLD). BUSY is combinational, so ID/EX stalls in the accept cycle itself.
- FLUSH in CALC, FIX or DONE: next state IDLE; RESULT_VALID=0 next cycle; no result is issued.
- FLUSH takes priority over HOLD.
- Signedness:
  - MULH: both operands signed.
  - MULHSU: A signed, B unsigned.
  - MULHU, DIVU, REMU: unsigned.
  - DIV, REM: signed.
  - Quotient sign = sign(A) xor sign(B); remainder sign = sign(A).
- Special cases (RISC-V defined, no trap):
  - Divide by zero: quotient = all ones; remainder = OP_A.
  - Signed overflow (A = 2^(XLEN-1), B = -1): quotient = A; remainder = 0.
- START while BUSY is high (not IDLE) is ignored. The pipeline guarantees it is re-presented.

Decomposition:
- Package mul_div_pkg:
  - FUNC3 constants: MUL=000, MULH=001, MULHSU=010, MULHU=011, DIV=100, DIVU=101, REM=110, REMU=111.
  - State encoding (2 bits).
  - Helper for N = XLEN/BITS_PER_CYCLE.
- One combinational sub-module mul_div_step: one BITS_PER_CYCLE-bit iteration slice (add-shift or subtract-compare), instantiated once and shared by multiply and divide.

Test Plan:
- MUL 7 * 0xFFFFFFFD (-3), RD=5 -> RESULT 0xFFFFFFEB, RESULT_RD 5, RESULT_VALID at cycle 34; BUSY high cycles 0-33.
- MULHU 0xFFFFFFFF * 0xFFFFFFFF -> 0xFFFFFFFE; MULHSU 0xFFFFFFFF * 2 -> 0xFFFFFFFF; MULH 0x80000000 * 0x80000000 -> 0x40000000.
- DIV -7/2 -> 0xFFFFFFFD; REM -7/2 -> 0xFFFFFFFF; DIVU 100/7 -> 14; REMU 100/7 -> 2.
- DIVU 5/0 -> 0xFFFFFFFF and REM 5/0 -> 5, valid 1 cycle after accept; DIV 0x80000000/0xFFFFFFFF -> 0x80000000 and REM -> 0, 1 cycle.
- FLUSH at cycle 10 of a DIV -> RESULT_VALID never asserts, BUSY low next cycle, new START MUL 3*4 accepted -> 12 after 34 cycles.
- HOLD=1 for 3 cycles in DONE -> RESULT, RESULT_RD, RESULT_VALID stable, BUSY high; BITS_PER_CYCLE=4 build: MUL 7*-3 -> 0xFFFFFFEB at cycle 10; RESET during CALC -> all outputs 0 next cycle.

Source files
------------

// File: rtl/mul_div_pkg.sv
// Shared definitions for the RV32M multiply/divide execute unit:
// funct3 op codes, controller state encoding and iteration-count helper.
package mul_div_pkg;

    // RV32M funct3 encodings
    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_MULHU  = 3'b011;
    localparam logic [2:0] F3_DIV    = 3'b100;
    localparam logic [2:0] F3_DIVU   = 3'b101;
    localparam logic [2:0] F3_REM    = 3'b110;
    localparam logic [2:0] F3_REMU   = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_CALC = 2'b01,
        ST_FIX  = 2'b10,
        ST_DONE = 2'b11
    } state_t;

    // Number of CALC iterations needed to resolve all operand bits
    function automatic int num_iters(input int xlen, input int bpc);
        return xlen / bpc;
    endfunction

endpackage

// File: rtl/mul_div_step.sv
// One iteration slice of the shared multiply/divide datapath. Resolves
// BITS_PER_CYCLE bits per call:
//   multiply: {hi,lo} holds {partial product, remaining multiplier};
//             add b when lo[0] is set, then shift the pair right.
//   divide:   {hi,lo} holds {partial remainder, dividend/quotient};
//             shift the pair left, subtract b when it fits, shift in the
//             quotient bit.
module mul_div_step #(
    parameter int XLEN           = 32,
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic            is_div_i,
    input  logic [XLEN-1:0] hi_i,
    input  logic [XLEN-1:0] lo_i,
    input  logic [XLEN-1:0] b_i,
    output logic [XLEN-1:0] hi_o,
    output logic [XLEN-1:0] lo_o
);

    logic [XLEN-1:0] hi_v;
    logic [XLEN-1:0] lo_v;
    logic [XLEN:0]   rem_v;
    logic [XLEN:0]   sum_v;

    // Unrolled BITS_PER_CYCLE single-bit add-shift / compare-subtract steps
    always_comb begin
        hi_v  = hi_i;
        lo_v  = lo_i;
        rem_v = '0;
        sum_v = '0;
        for (int k = 0; k < BITS_PER_CYCLE; k++) begin
            if (is_div_i) begin
                rem_v = {hi_v, lo_v[XLEN-1]};
                lo_v  = {lo_v[XLEN-2:0], 1'b0};
                if (rem_v >= {1'b0, b_i}) begin
                    rem_v   = rem_v - {1'b0, b_i};
                    lo_v[0] = 1'b1;
                end
                // Remainder is always below b after this step, so it fits XLEN bits
                hi_v = rem_v[XLEN-1:0];
            end else begin
                sum_v = {1'b0, hi_v} + (lo_v[0] ? {1'b0, b_i} : '0);
                lo_v  = {sum_v[0], lo_v[XLEN-1:1]};
                hi_v  = sum_v[XLEN:1];
            end
        end
        hi_o = hi_v;
        lo_o = lo_v;
    end

endmodule

// File: rtl/mul_div_unit.sv
// Iterative RV32M execute unit living beside the integer ALU in EX.
// Operands are converted to magnitudes on accept, the shared step slice
// runs N = XLEN/BITS_PER_CYCLE times, and a single FIX cycle re-applies the
// sign and selects the requested half / quotient / remainder. Divide-by-zero
// and signed overflow bypass the iteration and complete in one cycle.
module mul_div_unit
    import mul_div_pkg::*;
#(
    parameter int XLEN           = 32,
    parameter int BITS_PER_CYCLE = 1,
    parameter int REG_ADDR_W     = 5
) (
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic                  START,
    input  logic [2:0]            FUNC3,
    input  logic [XLEN-1:0]       OP_A,
    input  logic [XLEN-1:0]       OP_B,
    input  logic [REG_ADDR_W-1:0] RD_ADDR,
    input  logic                  FLUSH,
    input  logic                  HOLD,
    output logic                  BUSY,
    output logic                  RESULT_VALID,
    output logic [XLEN-1:0]       RESULT,
    output logic [REG_ADDR_W-1:0] RESULT_RD
);

    localparam int                PW       = 2 * XLEN;
    localparam int                N        = num_iters(XLEN, BITS_PER_CYCLE);
    localparam int                CNT_W    = $clog2(N + 1);
    localparam logic [CNT_W-1:0]  N_CNT    = CNT_W'(N);
    localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
    localparam logic [XLEN-1:0]   MIN_NEG  = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [XLEN-1:0]   ALL_ONES = {XLEN{1'b1}};

    state_t                  state_q, state_d;
    logic [2:0]              func3_q, func3_d;
    logic [REG_ADDR_W-1:0]   rd_q, rd_d;
    logic [REG_ADDR_W-1:0]   result_rd_q, result_rd_d;
    logic [XLEN-1:0]         hi_q, hi_d;
    logic [XLEN-1:0]         lo_q, lo_d;
    logic [XLEN-1:0]         b_q, b_d;
    logic [XLEN-1:0]         result_q, result_d;
    logic                    neg_q, neg_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;

    logic                    accept;
    logic                    a_signed, b_signed;
    logic                    sign_a, sign_b;
    logic                    neg_new;
    logic                    div_zero, div_ovf;
    logic [XLEN-1:0]         mag_a, mag_b;
    logic [XLEN-1:0]         special_res;
    logic [XLEN-1:0]         hi_step, lo_step;
    logic [PW-1:0]           prod, fix_prod;
    logic [XLEN-1:0]         div_sel, fix_div, fix_res;

    assign accept = START & ~FLUSH & (state_q == ST_IDLE);

    mul_div_step #(
        .XLEN           (XLEN),
        .BITS_PER_CYCLE (BITS_PER_CYCLE)
    ) u_step (
        .is_div_i (func3_q[2]),
        .hi_i     (hi_q),
        .lo_i     (lo_q),
        .b_i      (b_q),
        .hi_o     (hi_step),
        .lo_o     (lo_step)
    );

    // Operand decode: signedness, magnitudes, result sign and one-cycle special cases
    always_comb begin
        a_signed = (FUNC3 == F3_MULH) | (FUNC3 == F3_MULHSU) |
                   (FUNC3 == F3_DIV)  | (FUNC3 == F3_REM);
        b_signed = (FUNC3 == F3_MULH) | (FUNC3 == F3_DIV) | (FUNC3 == F3_REM);
        sign_a   = a_signed & OP_A[XLEN-1];
        sign_b   = b_signed & OP_B[XLEN-1];
        mag_a    = sign_a ? (~OP_A + XLEN'(1)) : OP_A;
        mag_b    = sign_b ? (~OP_B + XLEN'(1)) : OP_B;
        // Remainder follows the dividend; products and quotients follow sign(A)^sign(B)
        neg_new  = (FUNC3[2] & FUNC3[1]) ? sign_a : (sign_a ^ sign_b);
        div_zero = FUNC3[2] & (OP_B == '0);
        div_ovf  = FUNC3[2] & ~FUNC3[0] & (OP_A == MIN_NEG) & (OP_B == ALL_ONES);
        if (div_zero) begin
            special_res = FUNC3[1] ? OP_A : ALL_ONES;
        end else begin
            special_res = FUNC3[1] ? '0 : OP_A;
        end
    end

    // FIX-cycle result formation: sign restore and half / quotient / remainder select
    always_comb begin
        prod     = {hi_q, lo_q};
        fix_prod = neg_q ? (~prod + PW'(1)) : prod;
        div_sel  = func3_q[1] ? hi_q : lo_q;
        fix_div  = neg_q ? (~div_sel + XLEN'(1)) : div_sel;
        if (func3_q[2]) begin
            fix_res = fix_div;
        end else if (func3_q == F3_MUL) begin
            fix_res = fix_prod[XLEN-1:0];
        end else begin
            fix_res = fix_prod[PW-1:XLEN];
        end
    end

    // Controller next-state and datapath next values
    always_comb begin
        state_d     = state_q;
        func3_d     = func3_q;
        rd_d        = rd_q;
        result_rd_d = result_rd_q;
        hi_d        = hi_q;
        lo_d        = lo_q;
        b_d         = b_q;
        result_d    = result_q;
        neg_d       = neg_q;
        cnt_d       = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    func3_d = FUNC3;
                    rd_d    = RD_ADDR;
                    hi_d    = '0;
                    lo_d    = mag_a;
                    b_d     = mag_b;
                    neg_d   = neg_new;
                    cnt_d   = N_CNT;
                    if (div_zero | div_ovf) begin
                        result_d    = special_res;
                        result_rd_d = RD_ADDR;
                        state_d     = ST_DONE;
                    end else begin
                        state_d = ST_CALC;
                    end
                end
            end
            ST_CALC: begin
                if (FLUSH) begin
                    state_d = ST_IDLE;
                end else begin
                    hi_d  = hi_step;
                    lo_d  = lo_step;
                    cnt_d = cnt_q - CNT_ONE;
                    if (cnt_q == CNT_ONE) begin
                        state_d = ST_FIX;
                    end
                end
            end
            ST_FIX: begin
                if (FLUSH) begin
                    state_d = ST_IDLE;
                end else begin
                    result_d    = fix_res;
                    result_rd_d = rd_q;
                    state_d     = ST_DONE;
                end
            end
            ST_DONE: begin
                // A flush wins over a downstream hold
                if (FLUSH || !HOLD) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers; RESET clears everything
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q     <= ST_IDLE;
            func3_q     <= '0;
            rd_q        <= '0;
            result_rd_q <= '0;
            hi_q        <= '0;
            lo_q        <= '0;
            b_q         <= '0;
            result_q    <= '0;
            neg_q       <= 1'b0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            func3_q     <= func3_d;
            rd_q        <= rd_d;
            result_rd_q <= result_rd_d;
            hi_q        <= hi_d;
            lo_q        <= lo_d;
            b_q         <= b_d;
            result_q    <= result_d;
            neg_q       <= neg_d;
            cnt_q       <= cnt_d;
        end
    end

    assign BUSY         = accept | (state_q == ST_CALC) | (state_q == ST_FIX) |
                          ((state_q == ST_DONE) & HOLD);
    assign RESULT_VALID = (state_q == ST_DONE);
    assign RESULT       = result_q;
    assign RESULT_RD    = result_rd_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// Directed bench for mul_div_unit: a vector table of all M ops and special
// cases on a 1-bit/cycle instance, hand-written flush/hold/reset sequences,
// and a 4-bit/cycle instance for the short-latency build.
module tb_mul_div_unit;
    import mul_div_pkg::*;

    logic        CLK;
    logic        RESET;
    logic        START, START4;
    logic [2:0]  FUNC3;
    logic [31:0] OP_A, OP_B;
    logic [4:0]  RD_ADDR;
    logic        FLUSH, HOLD;
    logic        BUSY, RESULT_VALID;
    logic [31:0] RESULT;
    logic [4:0]  RESULT_RD;
    logic        BUSY4, RV4;
    logic [31:0] RES4;
    logic [4:0]  RD4;

    int n_checks = 0;
    int n_fail   = 0;

    mul_div_unit #(.XLEN(32), .BITS_PER_CYCLE(1), .REG_ADDR_W(5)) dut (
        .CLK(CLK), .RESET(RESET), .START(START), .FUNC3(FUNC3),
        .OP_A(OP_A), .OP_B(OP_B), .RD_ADDR(RD_ADDR), .FLUSH(FLUSH), .HOLD(HOLD),
        .BUSY(BUSY), .RESULT_VALID(RESULT_VALID), .RESULT(RESULT), .RESULT_RD(RESULT_RD)
    );

    mul_div_unit #(.XLEN(32), .BITS_PER_CYCLE(4), .REG_ADDR_W(5)) dut4 (
        .CLK(CLK), .RESET(RESET), .START(START4), .FUNC3(FUNC3),
        .OP_A(OP_A), .OP_B(OP_B), .RD_ADDR(RD_ADDR), .FLUSH(FLUSH), .HOLD(HOLD),
        .BUSY(BUSY4), .RESULT_VALID(RV4), .RESULT(RES4), .RESULT_RD(RD4)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    typedef struct {
        logic [2:0]  f3;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  rd;
        logic [31:0] exp;
        int          lat;
    } vec_t;

    vec_t vecs[15];

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic start_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                            input logic [4:0] rd, input bit four);
        FUNC3   = f3;
        OP_A    = a;
        OP_B    = b;
        RD_ADDR = rd;
        if (four) START4 = 1'b1;
        else      START  = 1'b1;
        #1;
    endtask

    // Counts edges from the accept cycle until RESULT_VALID; BUSY sampled every cycle before that
    task automatic wait_valid(input bit four, output int lat, output bit busy_ok);
        lat     = 0;
        busy_ok = 1'b1;
        while (lat < 200) begin
            if (!(four ? BUSY4 : BUSY)) busy_ok = 1'b0;
            tick();
            lat++;
            START  = 1'b0;
            START4 = 1'b0;
            if (four ? RV4 : RESULT_VALID) break;
        end
    endtask

    initial begin
        int  lat;
        bit  busy_ok;
        bit  seen;
        logic [31:0] last_res;

        vecs[0]  = '{F3_MUL,    32'd7,        32'hFFFFFFFD, 5'd5,  32'hFFFFFFEB, 34};
        vecs[1]  = '{F3_MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 5'd6,  32'hFFFFFFFE, 34};
        vecs[2]  = '{F3_MULHSU, 32'hFFFFFFFF, 32'd2,        5'd7,  32'hFFFFFFFF, 34};
        vecs[3]  = '{F3_MULH,   32'h80000000, 32'h80000000, 5'd8,  32'h40000000, 34};
        vecs[4]  = '{F3_DIV,    32'hFFFFFFF9, 32'd2,        5'd9,  32'hFFFFFFFD, 34};
        vecs[5]  = '{F3_REM,    32'hFFFFFFF9, 32'd2,        5'd10, 32'hFFFFFFFF, 34};
        vecs[6]  = '{F3_DIVU,   32'd100,      32'd7,        5'd11, 32'd14,       34};
        vecs[7]  = '{F3_REMU,   32'd100,      32'd7,        5'd12, 32'd2,        34};
        vecs[8]  = '{F3_DIVU,   32'd5,        32'd0,        5'd13, 32'hFFFFFFFF, 1};
        vecs[9]  = '{F3_REM,    32'd5,        32'd0,        5'd14, 32'd5,        1};
        vecs[10] = '{F3_DIV,    32'h80000000, 32'hFFFFFFFF, 5'd15, 32'h80000000, 1};
        vecs[11] = '{F3_REM,    32'h80000000, 32'hFFFFFFFF, 5'd16, 32'd0,        1};
        vecs[12] = '{F3_MULH,   32'hFFFFFFFD, 32'd7,        5'd17, 32'hFFFFFFFF, 34};
        vecs[13] = '{F3_REM,    32'd7,        32'hFFFFFFFE, 5'd18, 32'd1,        34};
        vecs[14] = '{F3_MUL,    32'h12345678, 32'h10,       5'd31, 32'h23456780, 34};

        RESET = 1'b1; START = 1'b0; START4 = 1'b0; FUNC3 = '0;
        OP_A = '0; OP_B = '0; RD_ADDR = '0; FLUSH = 1'b0; HOLD = 1'b0;
        tick();
        tick();
        check("reset_valid", RESULT_VALID, 0);
        check("reset_result", RESULT, 0);
        check("reset_rd", RESULT_RD, 0);
        check("reset_busy", BUSY, 0);
        RESET = 1'b0;
        tick();

        // Vector table
        for (int i = 0; i < 15; i++) begin
            start_op(vecs[i].f3, vecs[i].a, vecs[i].b, vecs[i].rd, 1'b0);
            wait_valid(1'b0, lat, busy_ok);
            check($sformatf("v%0d_latency", i), lat, vecs[i].lat);
            check($sformatf("v%0d_busy", i), busy_ok, 1);
            check($sformatf("v%0d_result", i), RESULT, vecs[i].exp);
            check($sformatf("v%0d_rd", i), RESULT_RD, vecs[i].rd);
            check($sformatf("v%0d_busy_done", i), BUSY, 0);
            tick();
            check($sformatf("v%0d_valid_drop", i), RESULT_VALID, 0);
            check($sformatf("v%0d_result_kept", i), RESULT, vecs[i].exp);
        end
        last_res = 32'h23456780;

        // START together with FLUSH in IDLE is ignored
        FLUSH = 1'b1;
        start_op(F3_MUL, 32'd9, 32'd9, 5'd1, 1'b0);
        check("flush_start_busy", BUSY, 0);
        tick();
        START = 1'b0;
        FLUSH = 1'b0;
        #1;
        check("flush_start_idle", BUSY, 0);
        check("flush_start_novalid", RESULT_VALID, 0);

        // FLUSH at cycle 10 of a DIV
        start_op(F3_DIV, 32'd100, 32'd7, 5'd3, 1'b0);
        tick();
        START = 1'b0;
        repeat (9) tick();
        FLUSH = 1'b1;
        tick();
        FLUSH = 1'b0;
        #1;
        check("flush_busy_low", BUSY, 0);
        check("flush_valid_low", RESULT_VALID, 0);
        seen = 1'b0;
        for (int c = 0; c < 40; c++) begin
            if (RESULT_VALID) seen = 1'b1;
            tick();
        end
        check("flush_no_result", seen, 0);
        check("flush_result_kept", RESULT, last_res);
        start_op(F3_MUL, 32'd3, 32'd4, 5'd4, 1'b0);
        wait_valid(1'b0, lat, busy_ok);
        check("post_flush_latency", lat, 34);
        check("post_flush_result", RESULT, 12);
        check("post_flush_rd", RESULT_RD, 4);
        tick();

        // HOLD keeps the result in DONE
        HOLD = 1'b1;
        start_op(F3_MUL, 32'd5, 32'd6, 5'd9, 1'b0);
        wait_valid(1'b0, lat, busy_ok);
        check("hold_latency", lat, 34);
        for (int c = 0; c < 3; c++) begin
            check($sformatf("hold%0d_valid", c), RESULT_VALID, 1);
            check($sformatf("hold%0d_result", c), RESULT, 30);
            check($sformatf("hold%0d_rd", c), RESULT_RD, 9);
            check($sformatf("hold%0d_busy", c), BUSY, 1);
            tick();
        end
        HOLD = 1'b0;
        #1;
        check("hold_release_busy", BUSY, 0);
        check("hold_release_valid", RESULT_VALID, 1);
        tick();
        check("hold_release_drop", RESULT_VALID, 0);

        // FLUSH beats HOLD in DONE
        HOLD = 1'b1;
        start_op(F3_MUL, 32'd2, 32'd3, 5'd11, 1'b0);
        wait_valid(1'b0, lat, busy_ok);
        check("flush_hold_result", RESULT, 6);
        FLUSH = 1'b1;
        tick();
        FLUSH = 1'b0;
        HOLD  = 1'b0;
        #1;
        check("flush_hold_valid", RESULT_VALID, 0);
        check("flush_hold_busy", BUSY, 0);

        // RESET during CALC
        start_op(F3_MUL, 32'd7, 32'hFFFFFFFD, 5'd20, 1'b0);
        tick();
        START = 1'b0;
        repeat (5) tick();
        RESET = 1'b1;
        tick();
        RESET = 1'b0;
        #1;
        check("rst_calc_valid", RESULT_VALID, 0);
        check("rst_calc_result", RESULT, 0);
        check("rst_calc_rd", RESULT_RD, 0);
        check("rst_calc_busy", BUSY, 0);
        tick();

        // 4 bits per cycle instance
        start_op(F3_MUL, 32'd7, 32'hFFFFFFFD, 5'd5, 1'b1);
        wait_valid(1'b1, lat, busy_ok);
        check("b4_mul_latency", lat, 10);
        check("b4_mul_busy", busy_ok, 1);
        check("b4_mul_result", RES4, 32'hFFFFFFEB);
        check("b4_mul_rd", RD4, 5);
        tick();
        start_op(F3_DIV, 32'hFFFFFFF9, 32'd2, 5'd21, 1'b1);
        wait_valid(1'b1, lat, busy_ok);
        check("b4_div_latency", lat, 10);
        check("b4_div_result", RES4, 32'hFFFFFFFD);
        tick();
        start_op(F3_REMU, 32'd100, 32'd7, 5'd22, 1'b1);
        wait_valid(1'b1, lat, busy_ok);
        check("b4_remu_latency", lat, 10);
        check("b4_remu_result", RES4, 32'd2);
        check("b4_remu_rd", RD4, 22);
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
